// File: rtl/scr1_tb_ahb_mem_mp.sv
// Multi-port AHB-Lite slave memory model: NPORTS slave ports share one byte-addressable
// array, each with a rotating wait-state pattern and two-cycle ERROR responses.
module scr1_tb_ahb_mem_mp #(
    parameter int unsigned NPORTS         = 2,
    parameter int unsigned MEM_POWER_SIZE = 16,
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_load,
    input  logic [NPORTS*32-1:0] stall_pattern_in,
    input  logic [NPORTS*3-1:0]  hsize,
    input  logic [NPORTS*2-1:0]  htrans,
    input  logic [NPORTS*AW-1:0] haddr,
    input  logic [NPORTS-1:0]    hwrite,
    input  logic [NPORTS*DW-1:0] hwdata,
    output logic [NPORTS-1:0]    hready,
    output logic [NPORTS*DW-1:0] hrdata,
    output logic [NPORTS-1:0]    hresp
);

    localparam int unsigned WIW = MEM_POWER_SIZE - 2;

    typedef enum logic [1:0] {StIdle, StData, StErr1, StErr2} state_e;

    // Deliberately not reset: contents survive a reset.
    logic [7:0]     mem     [2**MEM_POWER_SIZE];
    logic [3:0]     wr_be   [NPORTS];
    logic [WIW-1:0] wr_word [NPORTS];
    logic [31:0]    wr_data [NPORTS];

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        state_e                    state_q;
        logic [31:0]               pattern_q;
        logic [MEM_POWER_SIZE-1:0] addr_q;
        logic [2:0]                size_q;
        logic                      write_q;
        logic [31:0]               rdata_q;

        logic [AW-1:0]  a;
        logic [2:0]     sz;
        logic [31:0]    slice;
        logic           illegal;
        logic           complete;
        logic           accept;
        logic [WIW-1:0] word;
        logic [31:0]    rd_word;
        logic [3:0]     be;
        logic           unused_htrans;

        assign a             = haddr[p*AW +: AW];
        assign sz            = hsize[p*3 +: 3];
        assign slice         = stall_pattern_in[p*32 +: 32];
        assign unused_htrans = htrans[2*p];

        assign illegal = (sz > 3'd2)
                      || (sz == 3'd1 && a[0])
                      || (sz == 3'd2 && a[1:0] != 2'b00)
                      || (a[AW-1:MEM_POWER_SIZE] != '0);

        assign complete = (state_q == StData) && pattern_q[0];
        // HREADYOUT is high in IDLE and in the completion cycle; ERR2 never accepts.
        assign accept   = htrans[2*p+1] && ((state_q == StIdle) || complete);

        assign word    = addr_q[MEM_POWER_SIZE-1:2];
        assign rd_word = {mem[{word, 2'd3}], mem[{word, 2'd2}],
                          mem[{word, 2'd1}], mem[{word, 2'd0}]};

        always_comb begin
            be = 4'b0000;
            case (size_q)
                3'd0:    be[addr_q[1:0]] = 1'b1;
                3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
                default: be = 4'b1111;
            endcase
        end

        assign wr_be[p]   = (complete && write_q) ? be : 4'b0000;
        assign wr_word[p] = word;
        assign wr_data[p] = hwdata[p*DW +: 32];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= StIdle;
                pattern_q <= '1;
                addr_q    <= '0;
                size_q    <= '0;
                write_q   <= 1'b0;
                rdata_q   <= '0;
            end else begin
                // A zero pattern would stall forever, so it maps to all-ready.
                if (cfg_load) begin
                    pattern_q <= (slice == '0) ? '1 : slice;
                end else if (state_q == StData) begin
                    pattern_q <= {pattern_q[0], pattern_q[31:1]};
                end
                if (complete && !write_q) begin
                    rdata_q <= rd_word;
                end
                case (state_q)
                    StIdle, StData: begin
                        if (accept) begin
                            state_q <= illegal ? StErr1 : StData;
                            addr_q  <= a[MEM_POWER_SIZE-1:0];
                            size_q  <= sz;
                            write_q <= hwrite[p];
                        end else if (complete) begin
                            state_q <= StIdle;
                        end
                    end
                    StErr1:  state_q <= StErr2;
                    default: state_q <= StIdle;
                endcase
            end
        end

        assign hready[p]          = (state_q == StData) ? pattern_q[0] : (state_q != StErr1);
        assign hresp[p]           = (state_q == StErr1) || (state_q == StErr2);
        assign hrdata[p*DW +: 32] = (complete && !write_q) ? rd_word : rdata_q;
    end

    // Highest index is applied first so the lowest port wins an overlapping lane.
    always_ff @(posedge clk) begin
        for (int p = int'(NPORTS) - 1; p >= 0; p--) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[p][b]) begin
                    mem[{wr_word[p], 2'(b)}] <= wr_data[p][8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_scr1_tb_ahb_mem_mp.sv
// Scoreboard bench for the multi-port AHB memory model: directed transfers push expected
// responses, a negedge monitor pops and compares at each data-phase completion.
module tb_scr1_tb_ahb_mem_mp;

    localparam int NP = 2;

    logic            clk              = 1'b0;
    logic            rst_n            = 1'b0;
    logic            cfg_load         = 1'b0;
    logic [NP*32-1:0] stall_pattern_in = '0;
    logic [NP*3-1:0]  hsize           = '0;
    logic [NP*2-1:0]  htrans          = '0;
    logic [NP*32-1:0] haddr           = '0;
    logic [NP-1:0]    hwrite          = '0;
    logic [NP*32-1:0] hwdata          = '0;
    logic [NP-1:0]    hready;
    logic [NP*32-1:0] hrdata;
    logic [NP-1:0]    hresp;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rd;
        logic [31:0] data;
        logic        resp;
        int          waits;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    logic [NP-1:0] pend = '0;
    int            waits [NP];

    scr1_tb_ahb_mem_mp #(
        .NPORTS        (NP),
        .MEM_POWER_SIZE(16),
        .AW            (32),
        .DW            (32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_load        (cfg_load),
        .stall_pattern_in(stall_pattern_in),
        .hsize           (hsize),
        .htrans          (htrans),
        .haddr           (haddr),
        .hwrite          (hwrite),
        .hwdata          (hwdata),
        .hready          (hready),
        .hrdata          (hrdata),
        .hresp           (hresp)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endfunction

    // Monitor: completion = pending data phase with hready high.
    always @(negedge clk) begin
        exp_t e;
        bit   got;
        if (!rst_n) begin
            pend = '0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (pend[p]) begin
                    if (hready[p]) begin
                        got = 1'b0;
                        if (p == 0 && sb0.size() > 0) begin
                            e = sb0.pop_front();
                            got = 1'b1;
                        end else if (p == 1 && sb1.size() > 0) begin
                            e = sb1.pop_front();
                            got = 1'b1;
                        end
                        if (!got) begin
                            checks++;
                            failures++;
                            $display("FAIL p%0d_unexpected: got completion required none", p);
                        end else begin
                            chk($sformatf("p%0d_resp", p), 32'(hresp[p]), 32'(e.resp));
                            chk($sformatf("p%0d_waits", p), 32'(waits[p]), 32'(e.waits));
                            if (e.rd && !e.resp)
                                chk($sformatf("p%0d_rdata", p), hrdata[p*32 +: 32], e.data);
                        end
                        pend[p] = 1'b0;
                    end else begin
                        waits[p]++;
                    end
                end
                if (htrans[2*p+1] && hready[p]) begin
                    pend[p]  = 1'b1;
                    waits[p] = 0;
                end
            end
        end
    end

    task automatic xfer(input int p, input logic [31:0] a, input logic [2:0] sz,
                        input logic wr, input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_resp, input int exp_waits);
        exp_t e;
        int   n;
        e.rd    = !wr;
        e.data  = exp_rd;
        e.resp  = exp_resp;
        e.waits = exp_waits;
        @(posedge clk);
        #1;
        if (p == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        htrans[2*p +: 2] = 2'b10;
        haddr[32*p +: 32] = a;
        hsize[3*p +: 3]   = sz;
        hwrite[p]         = wr;
        @(posedge clk);
        #1;
        htrans[2*p +: 2]  = 2'b00;
        hwdata[32*p +: 32] = wd;
        n = 0;
        while (!hready[p] && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 64) begin
            checks++;
            failures++;
            $display("FAIL p%0d_timeout: got no hready required hready within 64 cycles", p);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_pattern(input logic [NP*32-1:0] pat);
        @(posedge clk);
        #1;
        stall_pattern_in = pat;
        cfg_load = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
    endtask

    function automatic void chk_idle(input string name, input int p);
        chk({name, "_hready"}, 32'(hready[p]), 32'd1);
        chk({name, "_hresp"}, 32'(hresp[p]), 32'd0);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish by 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("rst_p%0d_hready", p), 32'(hready[p]), 32'd1);
            chk($sformatf("rst_p%0d_hresp", p), 32'(hresp[p]), 32'd0);
            chk($sformatf("rst_p%0d_hrdata", p), hrdata[p*32 +: 32], 32'd0);
        end

        // Default pattern: zero wait states
        xfer(0, 32'h100, 3'd2, 1'b1, 32'h1234_5678, 32'h0, 1'b0, 0);
        xfer(0, 32'h100, 3'd2, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 0);

        // Port1 one wait per transfer; port0 slice 0 behaves as all-ready
        load_pattern({32'hAAAA_AAAA, 32'h0000_0000});
        xfer(1, 32'h104, 3'd2, 1'b1, 32'hCAFE_F00D, 32'h0, 1'b0, 1);
        xfer(1, 32'h104, 3'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 1);
        xfer(0, 32'h104, 3'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 0);

        // Sub-word writes
        xfer(0, 32'h103, 3'd0, 1'b1, 32'hEF00_0000, 32'h0, 1'b0, 0);
        xfer(0, 32'h100, 3'd2, 1'b0, 32'h0, 32'hEF34_5678, 1'b0, 0);
        xfer(0, 32'h102, 3'd1, 1'b1, 32'hBEEF_0000, 32'h0, 1'b0, 0);
        xfer(0, 32'h100, 3'd2, 1'b0, 32'h0, 32'hBEEF_5678, 1'b0, 0);
        xfer(0, 32'h101, 3'd1, 1'b1, 32'h0000_0000, 32'h0, 1'b1, 1);
        chk_idle("err_half_idle", 0);
        xfer(0, 32'h100, 3'd2, 1'b0, 32'h0, 32'hBEEF_5678, 1'b0, 0);

        // Out-of-range address and oversize transfer
        xfer(1, 32'h0001_0000, 3'd2, 1'b0, 32'h0, 32'h0, 1'b1, 1);
        chk_idle("err_range_idle", 1);
        xfer(0, 32'h0000_0000, 3'd3, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
        chk_idle("err_size_idle", 0);

        // Same-cycle writes: lowest port wins lane 0
        load_pattern({32'h0, 32'h0});
        fork
            xfer(0, 32'h200, 3'd0, 1'b1, 32'h0000_0011, 32'h0, 1'b0, 0);
            xfer(1, 32'h200, 3'd2, 1'b1, 32'hAABB_CCDD, 32'h0, 1'b0, 0);
        join
        xfer(0, 32'h200, 3'd2, 1'b0, 32'h0, 32'hAABB_CC11, 1'b0, 0);
        // Read concurrent with write to the same word sees pre-write data
        fork
            xfer(0, 32'h200, 3'd2, 1'b1, 32'h5566_7788, 32'h0, 1'b0, 0);
            xfer(1, 32'h200, 3'd2, 1'b0, 32'h0, 32'hAABB_CC11, 1'b0, 0);
        join
        xfer(1, 32'h200, 3'd2, 1'b0, 32'h0, 32'h5566_7788, 1'b0, 0);

        // Reset mid-DATA on a port1 write: array untouched, outputs reset
        xfer(0, 32'h300, 3'd2, 1'b1, 32'h0102_0304, 32'h0, 1'b0, 0);
        load_pattern({32'h8000_0000, 32'h0});
        @(posedge clk);
        #1;
        htrans[3:2]  = 2'b10;
        haddr[63:32] = 32'h300;
        hsize[5:3]   = 3'd2;
        hwrite[1]    = 1'b1;
        @(posedge clk);
        #1;
        htrans[3:2]   = 2'b00;
        hwdata[63:32] = 32'hDEAD_BEEF;
        chk("midrst_stalled", 32'(hready[1]), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_hready", 32'(hready), 32'h3);
        chk("midrst_hresp", 32'(hresp), 32'h0);
        chk("midrst_hrdata0", hrdata[31:0], 32'h0);
        chk("midrst_hrdata1", hrdata[63:32], 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hwrite = '0;
        xfer(0, 32'h300, 3'd2, 1'b0, 32'h0, 32'h0102_0304, 1'b0, 0);
        xfer(1, 32'h300, 3'd2, 1'b0, 32'h0, 32'h0102_0304, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb0.size() + sb1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scr1_tb_ahb_mem_mp.md
Name: scr1_tb_ahb_mem_mp

Overview:
- Parametrised multi-port AHB-Lite slave memory model for the SCR1 AHB testbench tops.
- Replaces the fixed imem/dmem pair with NPORTS identical slave ports sharing one byte-addressable array.
- Each port has a programmable rotating wait-state pattern, two-cycle ERROR responses for illegal accesses, and deterministic write arbitration.

Parameters:
- NPORTS, 2, number of AHB-Lite slave ports (1..8)
- MEM_POWER_SIZE, 16, array size is 2**MEM_POWER_SIZE bytes
- AW, 32, haddr width
- DW, 32, data width (fixed 32; other values are illegal)

Ports:
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- cfg_load  in  1  strobe: all pattern registers load from stall_pattern_in
- stall_pattern_in  in  NPORTS*32  per-port wait pattern; port p at bits [32p+31:32p]
- hsize  in  NPORTS*3  per-port transfer size
- htrans  in  NPORTS*2  per-port transfer type
- haddr  in  NPORTS*AW  per-port address
- hwrite  in  NPORTS  per-port write flag
- hwdata  in  NPORTS*32  per-port write data
- hready  out  NPORTS  per-port HREADYOUT
- hrdata  out  NPORTS*32  per-port read data
- hresp  out  NPORTS  per-port response, 1 = ERROR

Behaviour:
- Reset:
  - hready=1, hresp=0, hrdata=0.
  - All pattern regs = 32'hFFFF_FFFF; no data phase pending.
  - Array contents are not affected by reset.
- cfg_load=1 at a clock edge: every pattern reg loads its slice of stall_pattern_in. A slice of 0 loads 32'hFFFF_FFFF, so a port cannot lock up.
- Address phase accepted when htrans[1]=1 (NONSEQ/SEQ) and that port's hready=1. The block latches addr, size, write and the error decision. IDLE and BUSY are ignored.
- Per-port state machine:
  - IDLE -> DATA on accept of a legal transfer.
  - IDLE -> ERR1 on accept of an illegal transfer.
  - DATA: hready = pattern[0]. The pattern rotates right by 1 every cycle in DATA, whether ready or not. The DATA cycle with pattern[0]=1 is the completion cycle.
    - If a new transfer is accepted in the completion cycle -> DATA or ERR1, else -> IDLE.
  - ERR1: hready=0, hresp=1 -> ERR2.
  - ERR2: hready=1, hresp=1. No new transfer is accepted in ERR2 (AHB master cancels) -> IDLE.
- Illegal transfer:
  - hsize>2.
  - hsize=1 with addr[0]=1.
  - hsize=2 with addr[1:0]!=0.
  - addr >= 2**MEM_POWER_SIZE.
  - Illegal transfers never touch the array.
- Reads: hrdata holds the full aligned word in the completion cycle. Byte lanes are not masked. hrdata holds its last value otherwise.
- Writes:
  - hwdata is sampled in the completion cycle; the array updates at the end of that cycle.
  - Byte enables: hsize=0 enables lane addr[1:0]; hsize=1 enables lanes addr[1]*2 and +1; hsize=2 enables all four lanes.
- Same cycle, same word:
  - Writes from several ports merge per byte lane; on an overlapping lane the lowest port index wins.
  - A read completing in the same cycle as a write to that word returns pre-write data.
- Zero-wait latency: data returns in the cycle after the address phase.
- Reset mid-transfer: the pending phase is abandoned and no array write occurs. Outputs return to reset values asynchronously.

Test Plan:
- Reset, then hold IDLE on all ports 10 cycles -> hready=1, hresp=0, hrdata=0 on every port.
- Default pattern: port0 writes word 0x1234_5678 to 0x100, then reads 0x100 -> no wait states; read returns 0x1234_5678 one cycle after its address phase.
- cfg_load with port1 pattern 32'hAAAA_AAAA -> every port1 transfer takes exactly one wait cycle. Load slice 0 -> behaves as 32'hFFFF_FFFF.
- Byte write 0xEF at 0x103, then half write 0xBEEF at 0x102 with hsize=1 -> word read of 0x100 returns 0xBEEF_xx78 per lanes. A half write at 0x101 -> ERROR, array unchanged.
- Address 2**MEM_POWER_SIZE or hsize=3 -> exactly ERR1 (hready=0, hresp=1) then ERR2 (hready=1, hresp=1), then IDLE.
- Ports 0 and 1 complete writes to 0x200 in the same cycle: port0 byte lane0 0x11, port1 word 0xAABBCCDD -> word = 0xAABBCC11. Assert rst_n low mid-DATA on a write -> array unchanged and outputs at reset values.
